// File: rtl/npu_pool_act_unit_pkg.sv
// Shared encodings for the post-MAC pool/activation stage.
package npu_pool_act_unit_pkg;

  typedef enum logic [1:0] {
    POOL_N_1    = 2'd0,
    POOL_N_2    = 2'd1,
    POOL_N_4    = 2'd2,
    POOL_N_RSVD = 2'd3
  } pool_n_e;

  // Index of the last sample in a window; the reserved code behaves as a window of 1.
  function automatic logic [1:0] pool_last_idx(input logic [1:0] pool_n);
    case (pool_n)
      POOL_N_2: return 2'd1;
      POOL_N_4: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/npu_pool_act_unit_wr_fifo.sv
// Synchronous write FIFO with occupancy; pushes into a full FIFO and pops from an empty one are ignored.
module npu_pool_act_unit_wr_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/npu_pool_act_unit.sv
// Post-MAC stage: saturating bias add, optional ReLU, max-pool over 1/2/4 results,
// and a small write FIFO toward activation memory with an ack handshake.
module npu_pool_act_unit
  import npu_pool_act_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int PIX_WIDTH  = 9,
  parameter int CH_WIDTH   = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_layer_start,
  input  logic [1:0]            i_cfg_pool_n,
  input  logic                  i_cfg_relu_en,
  input  logic [ADDR_WIDTH-1:0] i_cfg_base_addr,
  input  logic [PIX_WIDTH-1:0]  i_cfg_pix_per_ch,
  input  logic [CH_WIDTH-1:0]   i_ch_num,
  input  logic                  i_mac_valid,
  input  logic [DATA_WIDTH-1:0] i_mac_out,
  input  logic [DATA_WIDTH-1:0] i_bias_data,
  output logic                  o_mac_ready,
  output logic                  o_wr_valid,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic                  i_wr_ack_p,
  output logic                  o_act_overflow,
  output logic                  o_ch_done_p
);

  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int MW = ADDR_WIDTH + CH_WIDTH + PIX_WIDTH;
  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [PIX_WIDTH-1:0]  PIX_ONE = PIX_WIDTH'(1);

  logic [1:0]            r_pool_n;
  logic                  r_relu_en;
  logic [PIX_WIDTH-1:0]  r_pix_per_ch;
  logic [ADDR_WIDTH-1:0] r_ch_offset;
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_sum;
  logic                  r_s1_ovf;
  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_s2_act;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [1:0]            r_win_cnt;
  logic [PIX_WIDTH-1:0]  r_pix_cnt;
  logic                  r_ch_done;

  logic [MW-1:0]         w_ch_prod;
  logic [ADDR_WIDTH-1:0] w_ch_offset;
  logic [DATA_WIDTH:0]   w_sum_ext;
  logic                  w_sum_ovf;
  logic [DATA_WIDTH-1:0] w_sum_sat;
  logic [DATA_WIDTH-1:0] w_act;
  logic [DATA_WIDTH-1:0] w_pool_max;
  logic                  w_push;
  logic                  w_pix_last;
  logic [ADDR_WIDTH-1:0] w_push_addr;
  logic [FW-1:0]         w_fifo_head;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [CW-1:0]         w_fifo_count;

  assign w_ch_prod   = MW'(i_ch_num) * MW'(i_cfg_pix_per_ch);
  assign w_ch_offset = w_ch_prod[ADDR_WIDTH-1:0] + i_cfg_base_addr;

  // One extra sign bit exposes overflow as a mismatch of the top two bits.
  assign w_sum_ext = {i_mac_out[DATA_WIDTH-1], i_mac_out} + {i_bias_data[DATA_WIDTH-1], i_bias_data};
  assign w_sum_ovf = w_sum_ext[DATA_WIDTH] ^ w_sum_ext[DATA_WIDTH-1];
  assign w_sum_sat = w_sum_ovf ? (w_sum_ext[DATA_WIDTH] ? SAT_NEG : SAT_POS)
                               : w_sum_ext[DATA_WIDTH-1:0];

  assign w_act = (r_relu_en && r_s1_sum[DATA_WIDTH-1]) ? '0 : r_s1_sum;

  assign w_pool_max  = ((r_win_cnt == 2'd0) || ($signed(r_s2_act) > $signed(r_acc))) ? r_s2_act : r_acc;
  assign w_push      = r_s2_valid && (r_win_cnt == pool_last_idx(r_pool_n));
  assign w_pix_last  = (r_pix_cnt == (r_pix_per_ch - PIX_ONE));
  assign w_push_addr = r_ch_offset + ADDR_WIDTH'(r_pix_cnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pool_n     <= '0;
      r_relu_en    <= 1'b0;
      r_pix_per_ch <= '0;
      r_ch_offset  <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_sum     <= '0;
      r_s1_ovf     <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_act     <= '0;
      r_acc        <= '0;
      r_win_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_ch_done    <= 1'b0;
    end else begin
      r_s1_valid <= i_mac_valid;
      r_s1_ovf   <= i_mac_valid && w_sum_ovf;
      if (i_mac_valid) r_s1_sum <= w_sum_sat;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_act <= w_act;
      r_ch_done <= w_push && w_pix_last;
      if (r_s2_valid) r_acc <= w_pool_max;
      // A push in the layer_start cycle already used the old config; counters restart after it.
      if (i_layer_start) begin
        r_pool_n     <= i_cfg_pool_n;
        r_relu_en    <= i_cfg_relu_en;
        r_pix_per_ch <= i_cfg_pix_per_ch;
        r_ch_offset  <= w_ch_offset;
        r_win_cnt    <= '0;
        r_pix_cnt    <= '0;
      end else if (r_s2_valid) begin
        if (w_push) begin
          r_win_cnt <= '0;
          r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + PIX_ONE;
        end else begin
          r_win_cnt <= r_win_cnt + 2'd1;
        end
      end
    end
  end

  npu_pool_act_unit_wr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  ({w_push_addr, w_pool_max}),
    .i_pop   (i_wr_ack_p),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  // Threshold leaves room for the two samples already inside S1/S2.
  assign o_mac_ready    = (w_fifo_count <= CW'(FIFO_DEPTH - 3));
  assign o_wr_valid     = !w_fifo_empty;
  assign o_wr_addr      = w_fifo_head[FW-1:DATA_WIDTH];
  assign o_wr_data      = w_fifo_head[DATA_WIDTH-1:0];
  assign o_act_overflow = r_s1_ovf || (w_push && w_fifo_full);
  assign o_ch_done_p    = r_ch_done;

endmodule

// File: tb/tb_npu_pool_act_unit.sv
// Directed bench for npu_pool_act_unit: per-scenario tasks with hand-computed expectations.
module tb_npu_pool_act_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        layer_start = 1'b0;
  logic [1:0]  cfg_pool_n = '0;
  logic        cfg_relu_en = 1'b0;
  logic [11:0] cfg_base_addr = '0;
  logic [8:0]  cfg_pix_per_ch = '0;
  logic [4:0]  ch_num = '0;
  logic        mac_valid = 1'b0;
  logic [15:0] mac_out = '0;
  logic [15:0] bias_data = '0;
  logic        mac_ready;
  logic        wr_valid;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack_p = 1'b0;
  logic        act_overflow;
  logic        ch_done_p;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  npu_pool_act_unit #(
    .DATA_WIDTH (16), .ADDR_WIDTH (12), .PIX_WIDTH (9), .CH_WIDTH (5), .FIFO_DEPTH (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_layer_start    (layer_start),
    .i_cfg_pool_n     (cfg_pool_n),
    .i_cfg_relu_en    (cfg_relu_en),
    .i_cfg_base_addr  (cfg_base_addr),
    .i_cfg_pix_per_ch (cfg_pix_per_ch),
    .i_ch_num         (ch_num),
    .i_mac_valid      (mac_valid),
    .i_mac_out        (mac_out),
    .i_bias_data      (bias_data),
    .o_mac_ready      (mac_ready),
    .o_wr_valid       (wr_valid),
    .o_wr_addr        (wr_addr),
    .o_wr_data        (wr_data),
    .i_wr_ack_p       (wr_ack_p),
    .o_act_overflow   (act_overflow),
    .o_ch_done_p      (ch_done_p)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [1:0] pool, input logic relu, input logic [11:0] base,
                             input logic [8:0] pix, input logic [4:0] ch);
    cfg_pool_n = pool; cfg_relu_en = relu; cfg_base_addr = base;
    cfg_pix_per_ch = pix; ch_num = ch; layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    tick();
  endtask

  task automatic send(input logic [15:0] m, input logic [15:0] b);
    mac_valid = 1'b1; mac_out = m; bias_data = b;
    tick();
    mac_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #22;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%0b exp=0", wr_valid); end
    checks++; if (mac_ready !== 1'b1) begin failures++; $display("FAIL reset_mac_ready got=%0b exp=1", mac_ready); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (act_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", act_overflow); end
    checks++; if (ch_done_p !== 1'b0) begin failures++; $display("FAIL reset_ch_done got=%0b exp=0", ch_done_p); end
    checks++; if (wr_addr !== 12'h000) begin failures++; $display("FAIL reset_wr_addr got=%h exp=000", wr_addr); end
    checks++; if (wr_data !== 16'h0000) begin failures++; $display("FAIL reset_wr_data got=%h exp=0000", wr_data); end
  endtask

  task automatic test_window4_relu();
    start_layer(2'd2, 1'b1, 12'h100, 9'd4, 5'd2);
    send(16'hFFFB, 16'h0000);
    send(16'h0003, 16'h0000);
    send(16'h0007, 16'h0000);
    send(16'h0002, 16'h0000);
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL win4_valid_t1 got=%0b exp=0", wr_valid); end
    tick();
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL win4_valid_t2 got=%0b exp=0", wr_valid); end
    tick();
    checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL win4_valid_t3 got=%0b exp=1", wr_valid); end
    checks++; if (wr_addr !== 12'h108) begin failures++; $display("FAIL win4_addr got=%h exp=108", wr_addr); end
    checks++; if (wr_data !== 16'h0007) begin failures++; $display("FAIL win4_data got=%h exp=0007", wr_data); end
    wr_ack_p = 1'b1; tick(); wr_ack_p = 1'b0;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL win4_drained got=%0b exp=0", wr_valid); end
  endtask

  task automatic test_neg_max();
    start_layer(2'd1, 1'b0, 12'h200, 9'd4, 5'd0);
    send(16'hFFF7, 16'h0000);
    send(16'hFFFC, 16'h0000);
    tick(); tick();
    checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL negmax_valid got=%0b exp=1", wr_valid); end
    checks++; if (wr_addr !== 12'h200) begin failures++; $display("FAIL negmax_addr got=%h exp=200", wr_addr); end
    checks++; if (wr_data !== 16'hFFFC) begin failures++; $display("FAIL negmax_data got=%h exp=FFFC", wr_data); end
    wr_ack_p = 1'b1; tick(); wr_ack_p = 1'b0;
  endtask

  task automatic test_saturation();
    logic [11:0] exp_addr [3];
    logic [15:0] exp_data [3];
    exp_addr = '{12'h308, 12'h309, 12'h30A};
    exp_data = '{16'h7FFF, 16'h8000, 16'h0002};
    start_layer(2'd0, 1'b0, 12'h300, 9'd8, 5'd1);
    send(16'h7000, 16'h2000);
    checks++; if (act_overflow !== 1'b1) begin failures++; $display("FAIL sat_pos_ovf got=%0b exp=1", act_overflow); end
    send(16'h8001, 16'hFFFE);
    checks++; if (act_overflow !== 1'b1) begin failures++; $display("FAIL sat_neg_ovf got=%0b exp=1", act_overflow); end
    send(16'h0005, 16'hFFFD);
    checks++; if (act_overflow !== 1'b0) begin failures++; $display("FAIL sat_none_ovf got=%0b exp=0", act_overflow); end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL sat_valid[%0d] got=%0b exp=1", i, wr_valid); end
      checks++; if (wr_addr !== exp_addr[i]) begin failures++; $display("FAIL sat_addr[%0d] got=%h exp=%h", i, wr_addr, exp_addr[i]); end
      checks++; if (wr_data !== exp_data[i]) begin failures++; $display("FAIL sat_data[%0d] got=%h exp=%h", i, wr_data, exp_data[i]); end
      wr_ack_p = 1'b1; tick(); wr_ack_p = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int first_nr = -1;
    int done_at = -1;
    int done_cnt = 0;
    int ovf_cnt = 0;
    start_layer(2'd0, 1'b0, 12'h040, 9'd4, 5'd0);
    bias_data = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      if (mac_ready) begin
        mac_valid = 1'b1; mac_out = 16'(10 + sent); sent++;
      end else begin
        mac_valid = 1'b0;
        if (first_nr < 0) first_nr = c;
      end
      tick();
      if (ch_done_p) begin done_cnt++; done_at = c; end
      if (act_overflow) ovf_cnt++;
    end
    mac_valid = 1'b0;
    checks++; if (sent !== 4) begin failures++; $display("FAIL bp_sent got=%0d exp=4", sent); end
    checks++; if (first_nr !== 4) begin failures++; $display("FAIL bp_ready_drop got=%0d exp=4", first_nr); end
    checks++; if (mac_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%0b exp=0", mac_ready); end
    checks++; if (done_cnt !== 1 || done_at !== 5) begin failures++; $display("FAIL bp_ch_done got=%0d@%0d exp=1@5", done_cnt, done_at); end
    checks++; if (ovf_cnt !== 0) begin failures++; $display("FAIL bp_overflow got=%0d exp=0", ovf_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, wr_valid); end
      checks++; if (wr_addr !== 12'(12'h040 + i)) begin failures++; $display("FAIL bp_addr[%0d] got=%h exp=%h", i, wr_addr, 12'(12'h040 + i)); end
      checks++; if (wr_data !== 16'(10 + i)) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, wr_data, 16'(10 + i)); end
      wr_ack_p = 1'b1; tick(); wr_ack_p = 1'b0;
    end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b exp=0", wr_valid); end
    checks++; if (mac_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%0b exp=1", mac_ready); end
    wr_ack_p = 1'b1; tick(); wr_ack_p = 1'b0;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL bp_ack_empty got=%0b exp=0", wr_valid); end
  endtask

  task automatic test_partial_window();
    start_layer(2'd2, 1'b0, 12'h500, 9'd4, 5'd0);
    send(16'd1, 16'd0); send(16'd2, 16'd0); send(16'd3, 16'd0); send(16'd4, 16'd0);
    send(16'd50, 16'd0); send(16'd60, 16'd0);
    tick(); tick();
    start_layer(2'd2, 1'b0, 12'h600, 9'd4, 5'd1);
    send(16'd5, 16'd0); send(16'd6, 16'd0); send(16'd7, 16'd0); send(16'd8, 16'd0);
    tick(); tick();
    checks++; if (wr_addr !== 12'h500 || wr_data !== 16'd4) begin failures++; $display("FAIL partial_old got=%h/%h exp=500/0004", wr_addr, wr_data); end
    wr_ack_p = 1'b1; tick(); wr_ack_p = 1'b0;
    checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL partial_new_valid got=%0b exp=1", wr_valid); end
    checks++; if (wr_addr !== 12'h604) begin failures++; $display("FAIL partial_new_addr got=%h exp=604", wr_addr); end
    checks++; if (wr_data !== 16'd8) begin failures++; $display("FAIL partial_new_data got=%h exp=0008", wr_data); end
    wr_ack_p = 1'b1; tick(); wr_ack_p = 1'b0;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL partial_empty got=%0b exp=0", wr_valid); end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    start_layer(2'd0, 1'b0, 12'h700, 9'd4, 5'd0);
    send(16'd1, 16'd0);
    mac_valid = 1'b1; mac_out = 16'd2; tick();
    mac_out = 16'd3; tick();
    checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%0b exp=1", wr_valid); end
    mac_out = 16'd4;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL arst_wr_valid got=%0b exp=0", wr_valid); end
    checks++; if (mac_ready !== 1'b1) begin failures++; $display("FAIL arst_mac_ready got=%0b exp=1", mac_ready); end
    mac_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wr_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL arst_no_write got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_window4_relu();
    test_neg_max();
    test_saturation();
    test_backpressure();
    test_partial_window();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
